uart_tx_buffered: RTL and testbench
===================================

# uart_tx_buffered

Buffered 8N1 UART transmitter that consumes the ASCII byte stream produced by the binary-to-ASCII serializer and drives the board's serial TX pin. Bytes arrive in bursts, at most one per `en_16_x_baud` tick, much faster than the line can drain them. A synchronous FIFO absorbs a full result dump: 48 digit characters plus CR and LF, 50 bytes. A bit-timing FSM then shifts the bytes out LSB-first at `en_16_x_baud`/16 bits per second.

## Interface
- `DEPTH`, 64: FIFO entries. Must be a power of two, ≥ 4.
- `AW`, $clog2(DEPTH): FIFO address width. Derived; do not override.
- `clk` input 1: system clock. All state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `en_16_x_baud` input 1: baud tick, one `clk` cycle wide, 16 per bit period.
- `data_in` input 8: byte to enqueue.
- `write_buffer` input 1: enqueue strobe. Sampled on each `clk` edge.
- `serial_out` output 1: UART TX line. Idle high.
- `buffer_full` output 1: FIFO holds DEPTH entries.
- `buffer_half_full` output 1: FIFO count ≥ DEPTH/2.
- `buffer_data_present` output 1: FIFO count ≠ 0.
- `tx_busy` output 1: FSM is not in IDLE.
- `overflow` output 1: sticky. Set when a write is dropped; cleared only by reset.

## Operation
- **Reset values:**
  - `serial_out`=1; all other outputs 0.
  - FIFO pointers and count = 0.
  - FSM = IDLE; tick and bit counters = 0.
- **FIFO write:**
  - `write_buffer`=1 with count < DEPTH: store `data_in` at wptr, then wptr++ (wraps mod DEPTH).
  - `write_buffer`=1 with count = DEPTH: byte dropped, `overflow` set.
  - Fullness is judged on the pre-edge count. A pop on the same edge does not make room for the write.
- **FIFO read:**
  - A pop happens only on the FSM transition into START. The popped byte goes to `shift_reg`, then rptr++ (wraps).
  - Simultaneous push and pop leaves count unchanged.
- **FSM (advances only on edges where `en_16_x_baud`=1):**
  - **IDLE:**
    - `serial_out`=1.
    - If FIFO is non-empty: pop, tick=0, go to START.
  - **START:**
    - `serial_out`=0.
    - After 16 ticks: bit=0, go to DATA.
  - **DATA:**
    - `serial_out`=`shift_reg[0]`.
    - After 16 ticks: shift right.
    - Bit 7 done: go to STOP. Otherwise bit++.
  - **STOP:**
    - `serial_out`=1.
    - After 16 ticks: if FIFO is non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- **Counter widths:**
  - tick counter 4 bits; the 16th tick is the one where tick wraps 15→0.
  - bit counter 3 bits.
  - count is AW+1 bits.
- `serial_out` is a registered output, glitch-free.

## Timing
- **Write latency:** a byte written on edge N is visible on `buffer_data_present` / `buffer_full` / `buffer_half_full` after edge N.
- **Start latency:** the first baud tick at or after edge N+1 pops the byte. `serial_out` falls on that edge.
- **Frame length:** exactly 160 baud ticks (start + 8 data + stop). Each bit lasts exactly 16 ticks.
- **Throughput:** back-to-back frames with a continuous stream, one byte per 160 ticks.
- **Baud tick rate:** `en_16_x_baud` may be 1 on every cycle, which gives a 16-cycle bit. No minimum spacing is required.
- **Reset mid-frame:**
  - `serial_out` goes to 1 immediately (asynchronously).
  - FIFO contents are discarded.
  - The partial frame is not resumed.
- **Writes during transmission** never disturb the byte already in `shift_reg`.

## Structure
- Shared package `uart_pkg`:
  - state enum `TX_IDLE`, `TX_START`, `TX_DATA`, `TX_STOP`
  - `TICKS_PER_BIT`=16, `DATA_BITS`=8
  - ASCII constants for 0, 1, CR, LF, shared with the serializer
- One sub-module, `sync_fifo`: params `WIDTH`, `DEPTH`; ports `push`, `pop`, `din`, `dout`, `full`, `half_full`, `empty`, `count`.
- The top level holds the FSM, counters and shift register.

## Test plan
- Reset, then write `0x31` with `en_16_x_baud` tied high:
  - `serial_out` = 0,1,0,0,0,1,1,0,0,1, each level exactly 16 cycles.
  - `tx_busy` drops after cycle 160.
  - `buffer_data_present` is 0 after the pop.
- 50-byte burst (48 × `'0'`/`'1'` pattern, then 0x0D, 0x0A), one per cycle, with `en_16_x_baud` every 4th cycle:
  - `overflow` stays 0; `buffer_half_full` goes high at 32 entries.
  - The decoded line output equals the input sequence, no gaps between frames, in 8000 ticks.
- `en_16_x_baud` held 0, write 65 bytes (0x00..0x40):
  - `buffer_full`=1 after the 64th write; the 65th is dropped and `overflow`=1.
  - Enabling the baud tick then emits 0x00..0x3F only.
- FIFO full, with write and FSM pop on the same edge:
  - The write is dropped and count becomes 63.
  - After draining, rptr/wptr wrap correctly and a following write of 0xA5 is transmitted intact.
- Assert `rst_n`=0 during DATA bit 3 of 0x55 with 5 bytes queued:
  - `serial_out`=1 immediately; all flags 0.
  - After release the line stays idle high until a new write.
- `en_16_x_baud` pulsed irregularly (gaps of 1–7 cycles):
  - Every bit spans exactly 16 pulses.
  - No state change occurs on edges where `en_16_x_baud`=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter states, frame geometry and the ASCII
// codes exchanged with the binary-to-ASCII serializer.
package uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  localparam int TICKS_PER_BIT = 16;
  localparam int DATA_BITS     = 8;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_1  = 8'h31;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational read port. Fullness and emptiness
// are judged on the pre-edge count, so a pop never makes room for a push on the same edge.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             half_full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_HALF = (AW+1)'(DEPTH / 2);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    full      = (count_q == CNT_FULL);
    half_full = (count_q >= CNT_HALF);
    empty     = (count_q == '0);
    count     = count_q;
    dout      = mem_q[rptr_q];
    do_push   = push & ~full;
    do_pop    = pop & ~empty;
    wptr_d    = do_push ? wptr_q + 1'b1 : wptr_q;
    rptr_d    = do_pop  ? rptr_q + 1'b1 : rptr_q;
    count_d   = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: a FIFO absorbs byte bursts and a baud-tick
// driven FSM shifts each byte out LSB-first, back-to-back while data remains.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_16_x_baud,
  input  logic [7:0] data_in,
  input  logic       write_buffer,
  output logic       serial_out,
  output logic       buffer_full,
  output logic       buffer_half_full,
  output logic       buffer_data_present,
  output logic       tx_busy,
  output logic       overflow
);

  localparam logic [3:0] TICK_LAST = 4'(TICKS_PER_BIT - 1);
  localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

  tx_state_e   state_q, state_d;
  logic [3:0]  tick_q, tick_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        serial_q, serial_d;
  logic        overflow_q, overflow_d;
  logic        fifo_pop, fifo_full, fifo_half, fifo_empty;
  logic [7:0]  fifo_dout;
  logic [AW:0] fifo_count;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (write_buffer),
    .pop       (fifo_pop),
    .din       (data_in),
    .dout      (fifo_dout),
    .full      (fifo_full),
    .half_full (fifo_half),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    fifo_pop   = 1'b0;
    overflow_d = overflow_q | (write_buffer & fifo_full);
    if (en_16_x_baud) begin
      case (state_q)
        TX_IDLE: begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            tick_d   = '0;
            state_d  = TX_START;
          end
        end
        TX_START: begin
          tick_d = tick_q + 1'b1;
          if (tick_q == TICK_LAST) begin
            bit_d   = '0;
            state_d = TX_DATA;
          end
        end
        TX_DATA: begin
          tick_d = tick_q + 1'b1;
          if (tick_q == TICK_LAST) begin
            shift_d = {1'b0, shift_q[7:1]};
            if (bit_q == BIT_LAST) state_d = TX_STOP;
            else                   bit_d   = bit_q + 1'b1;
          end
        end
        TX_STOP: begin
          tick_d = tick_q + 1'b1;
          if (tick_q == TICK_LAST) begin
            // Chain straight into the next start bit so a burst leaves no idle gap.
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shift_d  = fifo_dout;
              state_d  = TX_START;
            end else begin
              state_d  = TX_IDLE;
            end
          end
        end
        default: state_d = TX_IDLE;
      endcase
    end
    // Line level is registered from the next state so the pin never glitches.
    case (state_d)
      TX_START: serial_d = 1'b0;
      TX_DATA:  serial_d = shift_d[0];
      default:  serial_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= TX_IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      serial_q   <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      serial_q   <= serial_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  always_comb begin
    serial_out          = serial_q;
    buffer_full         = fifo_full;
    buffer_half_full    = fifo_half;
    buffer_data_present = (fifo_count != '0);
    tx_busy             = (state_q != TX_IDLE);
    overflow            = overflow_q;
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered: written bytes are queued as expected
// frames and a line monitor decodes serial_out tick by tick and compares.
module tb_uart_tx_buffered;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en_16_x_baud = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       write_buffer = 1'b0;
  logic       serial_out, buffer_full, buffer_half_full, buffer_data_present, tx_busy, overflow;

  uart_tx_buffered #(.DEPTH(64)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .en_16_x_baud        (en_16_x_baud),
    .data_in             (data_in),
    .write_buffer        (write_buffer),
    .serial_out          (serial_out),
    .buffer_full         (buffer_full),
    .buffer_half_full    (buffer_half_full),
    .buffer_data_present (buffer_data_present),
    .tx_busy             (tx_busy),
    .overflow            (overflow)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] sb[$];
  bit         mon_active = 1'b0;
  bit         have_end = 1'b0;
  int         tick_cnt = 0;
  int         end_tick = 0;
  int         b2b = 0;
  int         en_mode = 0;
  int         ctr = 0;
  int         gap = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Line monitor: samples after each rising edge; decodes 160-tick frames.
  initial begin : monitor
    logic         prev, tk, same;
    logic [159:0] lv;
    logic [7:0]   byte_v, exp_v;
    int           idx;
    prev = 1'b1;
    idx  = 0;
    lv   = '0;
    forever begin
      @(posedge clk);
      tk = en_16_x_baud;
      #1;
      if (!rst_n) begin
        mon_active = 1'b0;
        prev = serial_out;
        continue;
      end
      if (!tk) begin
        chk("hold_no_tick", {31'd0, serial_out}, {31'd0, prev});
      end else begin
        tick_cnt++;
        if (mon_active) begin
          lv[idx] = serial_out;
          idx++;
          if (idx == 160) begin
            for (int b = 0; b < 10; b++) begin
              same = 1'b1;
              for (int k = 1; k < 16; k++)
                if (lv[16*b+k] !== lv[16*b]) same = 1'b0;
              chk("bit_width", {31'd0, same}, 32'd1);
            end
            chk("stop_bit", {31'd0, lv[144]}, 32'd1);
            for (int b = 0; b < 8; b++) byte_v[b] = lv[16*(b+1)];
            if (sb.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_frame: got %02h required none", byte_v);
            end else begin
              exp_v = sb.pop_front();
              chk("rx_byte", {24'd0, byte_v}, {24'd0, exp_v});
            end
            mon_active = 1'b0;
            end_tick = tick_cnt;
            have_end = 1'b1;
          end
        end else if (prev && !serial_out) begin
          if (have_end && tick_cnt == end_tick + 1) b2b++;
          mon_active = 1'b1;
          lv = '0;
          idx = 1;
        end
      end
      prev = serial_out;
    end
  end

  // Drives inputs for the next rising edge and returns at the following falling edge.
  task automatic cyc(input logic wr, input logic [7:0] d);
    write_buffer = wr;
    data_in = d;
    case (en_mode)
      0: en_16_x_baud = 1'b0;
      1: en_16_x_baud = 1'b1;
      2: en_16_x_baud = (ctr % 4 == 0);
      default: begin
        if (gap == 0) begin
          en_16_x_baud = 1'b1;
          gap = $urandom_range(1, 7);
        end else begin
          en_16_x_baud = 1'b0;
          gap--;
        end
      end
    endcase
    ctr++;
    @(negedge clk);
  endtask

  task automatic put(input logic [7:0] d);
    sb.push_back(d);
    cyc(1'b1, d);
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while ((sb.size() != 0 || mon_active || tx_busy || buffer_data_present) && n < maxc) begin
      cyc(1'b0, 8'h00);
      n++;
    end
    chk("drain_in_budget", {31'd0, (n < maxc)}, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    write_buffer = 1'b0;
    en_16_x_baud = 1'b0;
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [47:0] pat;
    int          c, lows, busys, b0;
    pat = 48'hA5C3_0F96_33CC;

    // Reset values
    @(negedge clk);
    chk("rst_serial", {31'd0, serial_out}, 32'd1);
    chk("rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("rst_present", {31'd0, buffer_data_present}, 32'd0);
    chk("rst_full", {31'd0, buffer_full}, 32'd0);
    chk("rst_half", {31'd0, buffer_half_full}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single byte 0x31 with the tick on every cycle
    en_mode = 1;
    put(8'h31);
    chk("t1_present_after_write", {31'd0, buffer_data_present}, 32'd1);
    chk("t1_busy_before_pop", {31'd0, tx_busy}, 32'd0);
    cyc(1'b0, 8'h00);
    chk("t1_busy_after_pop", {31'd0, tx_busy}, 32'd1);
    chk("t1_present_after_pop", {31'd0, buffer_data_present}, 32'd0);
    chk("t1_start_low", {31'd0, serial_out}, 32'd0);
    repeat (159) cyc(1'b0, 8'h00);
    chk("t1_busy_last_cycle", {31'd0, tx_busy}, 32'd1);
    cyc(1'b0, 8'h00);
    chk("t1_busy_drop", {31'd0, tx_busy}, 32'd0);
    chk("t1_line_idle", {31'd0, serial_out}, 32'd1);
    drain(50);

    // 50-byte result dump, tick every 4th cycle
    en_mode = 2;
    ctr = 0;
    b0 = b2b;
    for (int i = 0; i < 50; i++) begin
      if (i < 48) put(pat[i] ? ASCII_1 : ASCII_0);
      else        put(i == 48 ? ASCII_CR : ASCII_LF);
      c = (i < 4) ? i + 1 : i;
      chk("t2_half_full", {31'd0, buffer_half_full}, {31'd0, (c >= 32)});
    end
    chk("t2_overflow", {31'd0, overflow}, 32'd0);
    drain(34000);
    chk("t2_back_to_back", b2b - b0, 32'd49);
    chk("t2_overflow_end", {31'd0, overflow}, 32'd0);

    // Overfill with the tick held low
    en_mode = 0;
    for (int i = 0; i < 65; i++) begin
      if (i < 64) put(8'(i));
      else        cyc(1'b1, 8'(i));
      if (i == 63) begin
        chk("t3_full_64", {31'd0, buffer_full}, 32'd1);
        chk("t3_ovf_before", {31'd0, overflow}, 32'd0);
      end
    end
    chk("t3_full_65", {31'd0, buffer_full}, 32'd1);
    chk("t3_ovf_after", {31'd0, overflow}, 32'd1);
    en_mode = 1;
    b0 = b2b;
    drain(12000);
    chk("t3_back_to_back", b2b - b0, 32'd63);

    // Full FIFO: write collides with a pop, then pointer wrap
    do_reset();
    chk("t4_ovf_cleared", {31'd0, overflow}, 32'd0);
    en_mode = 0;
    for (int i = 0; i < 64; i++) put(8'(i) ^ 8'h5A);
    chk("t4_full", {31'd0, buffer_full}, 32'd1);
    en_mode = 1;
    cyc(1'b1, 8'hEE);
    chk("t4_full_after_collide", {31'd0, buffer_full}, 32'd0);
    chk("t4_half_after_collide", {31'd0, buffer_half_full}, 32'd1);
    chk("t4_ovf_collide", {31'd0, overflow}, 32'd1);
    chk("t4_busy", {31'd0, tx_busy}, 32'd1);
    drain(12000);
    put(8'hA5);
    drain(400);

    // Reset during data bit 3 of 0x55 with five bytes queued
    en_mode = 1;
    put(8'h55);
    for (int i = 0; i < 5; i++) put(8'h10 + 8'(i));
    repeat (64) cyc(1'b0, 8'h00);
    chk("t5_bit3_low", {31'd0, serial_out}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_serial_async", {31'd0, serial_out}, 32'd1);
    chk("t5_present", {31'd0, buffer_data_present}, 32'd0);
    chk("t5_busy", {31'd0, tx_busy}, 32'd0);
    chk("t5_full", {31'd0, buffer_full}, 32'd0);
    chk("t5_half", {31'd0, buffer_half_full}, 32'd0);
    chk("t5_ovf", {31'd0, overflow}, 32'd0);
    sb.delete();
    write_buffer = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    busys = 0;
    repeat (300) begin
      cyc(1'b0, 8'h00);
      if (!serial_out) lows++;
      if (tx_busy) busys++;
    end
    chk("t5_idle_low_cycles", lows, 32'd0);
    chk("t5_idle_busy_cycles", busys, 32'd0);
    put(8'h3C);
    drain(400);

    // Irregular baud ticks
    en_mode = 3;
    gap = 0;
    put(8'h96);
    put(8'hC3);
    drain(6000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
